// File: rtl/data_bus_mux.sv
// Data-side interconnect: address decode, in-order response routing and an error responder.
// Optional profiling counters are enabled with `define DATA_BUS_PROFILE_EN.
module data_bus_mux #(
  parameter int                     N_SLAVES        = 3,
  parameter logic [N_SLAVES*32-1:0] SLV_BASE        = {32'h20002000, 32'h20001000, 32'h00100000},
  parameter logic [N_SLAVES*32-1:0] SLV_MASK        = {32'hFFFFF000, 32'hFFFFF000, 32'hFFFF8000},
  parameter int                     MAX_OUTSTANDING = 2,
  parameter logic [31:0]            ERR_RDATA       = 32'hDEADBEEF
) (
  input  logic                     HCLK,
  input  logic                     HRESET,
  input  logic                     data_req,
  input  logic [31:0]              data_addr,
  input  logic                     data_we,
  input  logic [3:0]               data_be,
  input  logic [31:0]              data_wdata,
  output logic                     data_gnt,
  output logic                     data_rvalid,
  output logic [31:0]              data_rdata,
  output logic                     data_err,
  output logic [N_SLAVES-1:0]      slv_req,
  output logic [31:0]              slv_addr,
  output logic                     slv_we,
  output logic [3:0]               slv_be,
  output logic [31:0]              slv_wdata,
  input  logic [N_SLAVES-1:0]      slv_gnt,
  input  logic [N_SLAVES-1:0]      slv_rvalid,
  input  logic [N_SLAVES*32-1:0]   slv_rdata,
  output logic [31:0]              prof_rd,
  output logic [31:0]              prof_wr,
  output logic [31:0]              prof_stall,
  output logic [31:0]              prof_err
);

  localparam int TW = $clog2(N_SLAVES + 1);
  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam logic [TW-1:0] ERR_IDX  = TW'(N_SLAVES);
  localparam logic [CW-1:0] DEPTH    = CW'(MAX_OUTSTANDING);
  localparam logic [PW-1:0] LAST_PTR = PW'(MAX_OUTSTANDING - 1);

  logic [TW-1:0] fifo_q [MAX_OUTSTANDING];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count;
  logic [TW-1:0] last_tgt;
  logic [TW-1:0] tgt, head;
  logic          fifo_empty, fifo_full, stall, push, pop;

  assign slv_addr  = data_addr;
  assign slv_we    = data_we;
  assign slv_be    = data_be;
  assign slv_wdata = data_wdata;

  // Descending scan so the lowest matching index is the one left standing.
  always_comb begin
    tgt = ERR_IDX;
    for (int i = N_SLAVES - 1; i >= 0; i--) begin
      if ((data_addr & SLV_MASK[i*32 +: 32]) == SLV_BASE[i*32 +: 32]) tgt = TW'(i);
    end
  end

  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == DEPTH);
  assign stall      = fifo_full | (!fifo_empty && (tgt != last_tgt));
  assign head       = fifo_q[rd_ptr];

  always_comb begin
    slv_req  = '0;
    data_gnt = 1'b0;
    if (!stall) begin
      if (tgt == ERR_IDX) data_gnt = data_req;
      for (int i = 0; i < N_SLAVES; i++) begin
        if (tgt == TW'(i)) begin
          slv_req[i] = data_req;
          data_gnt   = slv_gnt[i];
        end
      end
    end
  end

  always_comb begin
    data_rvalid = 1'b0;
    data_rdata  = '0;
    data_err    = 1'b0;
    if (!fifo_empty) begin
      if (head == ERR_IDX) begin
        data_rvalid = 1'b1;
        data_rdata  = ERR_RDATA;
        data_err    = 1'b1;
      end
      for (int i = 0; i < N_SLAVES; i++) begin
        if (head == TW'(i)) begin
          data_rvalid = slv_rvalid[i];
          data_rdata  = slv_rdata[i*32 +: 32];
        end
      end
    end
  end

  assign push = data_req & data_gnt;
  assign pop  = data_rvalid;

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      last_tgt <= ERR_IDX;
    end else begin
      if (push) begin
        fifo_q[wr_ptr] <= tgt;
        wr_ptr         <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + PW'(1);
        last_tgt       <= tgt;
      end
      if (pop) rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + PW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
    end
  end

`ifdef DATA_BUS_PROFILE_EN
  logic [31:0] rd_cnt, wr_cnt, stall_cnt, err_cnt;

  // All four counters saturate at all-ones.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      rd_cnt    <= '0;
      wr_cnt    <= '0;
      stall_cnt <= '0;
      err_cnt   <= '0;
    end else begin
      if (push && !data_we && rd_cnt != '1)         rd_cnt    <= rd_cnt + 32'd1;
      if (push && data_we && wr_cnt != '1)          wr_cnt    <= wr_cnt + 32'd1;
      if (data_req && !data_gnt && stall_cnt != '1) stall_cnt <= stall_cnt + 32'd1;
      if (data_rvalid && data_err && err_cnt != '1) err_cnt   <= err_cnt + 32'd1;
    end
  end

  assign prof_rd    = rd_cnt;
  assign prof_wr    = wr_cnt;
  assign prof_stall = stall_cnt;
  assign prof_err   = err_cnt;
`else
  assign prof_rd    = '0;
  assign prof_wr    = '0;
  assign prof_stall = '0;
  assign prof_err   = '0;
`endif

endmodule

// File: tb/tb_data_bus_mux.sv
// Self-checking bench for data_bus_mux: directed scenarios then randomized traffic
// against an in-order transaction model with behavioural slaves.
module tb_data_bus_mux;
  localparam int N    = 3;
  localparam int MAXO = 2;

  logic            HCLK = 1'b0;
  logic            HRESET;
  logic            data_req;
  logic [31:0]     data_addr;
  logic            data_we;
  logic [3:0]      data_be;
  logic [31:0]     data_wdata;
  logic            data_gnt;
  logic            data_rvalid;
  logic [31:0]     data_rdata;
  logic            data_err;
  logic [N-1:0]    slv_req;
  logic [31:0]     slv_addr;
  logic            slv_we;
  logic [3:0]      slv_be;
  logic [31:0]     slv_wdata;
  logic [N-1:0]    slv_gnt;
  logic [N-1:0]    slv_rvalid;
  logic [N*32-1:0] slv_rdata;
  logic [31:0]     prof_rd, prof_wr, prof_stall, prof_err;

  always #5 HCLK = ~HCLK;

  data_bus_mux #(
    .N_SLAVES(N),
    .SLV_BASE({32'h20002000, 32'h20001000, 32'h00100000}),
    .SLV_MASK({32'hFFFFF000, 32'hFFFFF000, 32'hFFFF8000}),
    .MAX_OUTSTANDING(MAXO),
    .ERR_RDATA(32'hDEADBEEF)
  ) dut (
    .HCLK(HCLK), .HRESET(HRESET),
    .data_req(data_req), .data_addr(data_addr), .data_we(data_we), .data_be(data_be),
    .data_wdata(data_wdata), .data_gnt(data_gnt), .data_rvalid(data_rvalid),
    .data_rdata(data_rdata), .data_err(data_err),
    .slv_req(slv_req), .slv_addr(slv_addr), .slv_we(slv_we), .slv_be(slv_be),
    .slv_wdata(slv_wdata), .slv_gnt(slv_gnt), .slv_rvalid(slv_rvalid), .slv_rdata(slv_rdata),
    .prof_rd(prof_rd), .prof_wr(prof_wr), .prof_stall(prof_stall), .prof_err(prof_err)
  );

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  // Transaction model: targets in flight, oldest first; N means the error responder.
  int mq[$];
  int m_last = -1;
  int m_rd = 0, m_wr = 0, m_stall = 0, m_perr = 0;

  // Behavioural slaves: pending responses with the cycle they become ready.
  logic [31:0] sq_data [N][$];
  int          sq_rdy  [N][$];
  int gnt_pct = 100, lat_min = 1, lat_max = 1, stray_pct = 0;
  logic [31:0] next_data = 32'h0;
  bit          use_next = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [31:0] prof_exp(input int v);
`ifdef DATA_BUS_PROFILE_EN
    return 32'(v);
`else
    return (v == v) ? 32'h0 : 32'h0;
`endif
  endfunction

  // One clock cycle: drive at negedge, check outputs, then advance the model to the next edge.
  task automatic cycle(input bit rst, input bit req, input logic [31:0] addr, input bit we, input int tgt);
    bit          stall, exp_gnt, exp_rv, exp_er, push, pop;
    logic [N-1:0] exp_req;
    logic [31:0] exp_rd;
    int          h;
    @(negedge HCLK);
    HRESET     = rst;
    data_req   = req;
    data_addr  = addr;
    data_we    = we;
    data_be    = 4'($urandom);
    data_wdata = $urandom;
    for (int i = 0; i < N; i++) begin
      slv_gnt[i] = ($urandom_range(99) < gnt_pct);
      if (sq_data[i].size() > 0 && sq_rdy[i][0] <= cyc) begin
        slv_rvalid[i]          = 1'b1;
        slv_rdata[i*32 +: 32]  = sq_data[i][0];
      end else begin
        slv_rvalid[i]          = (sq_data[i].size() == 0) && ($urandom_range(99) < stray_pct);
        slv_rdata[i*32 +: 32]  = $urandom;
      end
    end
    #1;
    stall   = (mq.size() == MAXO) || (mq.size() > 0 && tgt != m_last);
    exp_req = '0;
    exp_gnt = 1'b0;
    if (!stall) begin
      if (tgt == N) exp_gnt = req;
      else begin
        exp_req[tgt] = req;
        exp_gnt      = slv_gnt[tgt];
      end
    end
    exp_rv = 1'b0; exp_er = 1'b0; exp_rd = 32'h0;
    if (mq.size() > 0) begin
      h = mq[0];
      if (h == N) begin
        exp_rv = 1'b1; exp_er = 1'b1; exp_rd = 32'hDEADBEEF;
      end else begin
        exp_rv = slv_rvalid[h]; exp_rd = slv_rdata[h*32 +: 32];
      end
    end
    chk("data_gnt", 32'(data_gnt), 32'(exp_gnt));
    chk("slv_req", 32'(slv_req), 32'(exp_req));
    chk("data_rvalid", 32'(data_rvalid), 32'(exp_rv));
    if (exp_rv) begin
      chk("data_err", 32'(data_err), 32'(exp_er));
      chk("data_rdata", data_rdata, exp_rd);
    end
    chk("slv_addr", slv_addr, addr);
    chk("prof_rd", prof_rd, prof_exp(m_rd));
    chk("prof_wr", prof_wr, prof_exp(m_wr));
    chk("prof_stall", prof_stall, prof_exp(m_stall));
    chk("prof_err", prof_err, prof_exp(m_perr));
    push = req && exp_gnt;
    pop  = exp_rv;
    if (rst) begin
      mq.delete();
      m_rd = 0; m_wr = 0; m_stall = 0; m_perr = 0;
    end else begin
      if (pop) void'(mq.pop_front());
      if (push) begin
        mq.push_back(tgt);
        m_last = tgt;
        if (we) m_wr++; else m_rd++;
      end
      if (req && !exp_gnt) m_stall++;
      if (exp_rv && exp_er) m_perr++;
    end
    for (int i = 0; i < N; i++) begin
      if (slv_rvalid[i] && sq_data[i].size() > 0) begin
        void'(sq_data[i].pop_front());
        void'(sq_rdy[i].pop_front());
      end
      if (exp_req[i] && slv_gnt[i]) begin
        sq_data[i].push_back(use_next ? next_data : $urandom);
        sq_rdy[i].push_back(cyc + $urandom_range(lat_max, lat_min));
      end
    end
    cyc++;
  endtask

  task automatic idle();
    cycle(1'b0, 1'b0, 32'h0, 1'b0, N);
  endtask

  function automatic logic [31:0] rand_addr(input int t);
    case (t)
      0: return 32'h00100000 | ($urandom & 32'h00007FFF);
      1: return 32'h20001000 | ($urandom & 32'h00000FFF);
      2: return 32'h20002000 | ($urandom & 32'h00000FFF);
      default: begin
        case ($urandom_range(2))
          0: return 32'h00108000 | ($urandom & 32'h00000FFF);
          1: return 32'h20000FFC;
          default: return 32'h30000000 | ($urandom & 32'h000FFFFF);
        endcase
      end
    endcase
  endfunction

  initial begin
    int t;
    HRESET = 1'b1; data_req = 1'b0; data_addr = '0; data_we = 1'b0; data_be = '0;
    data_wdata = '0; slv_gnt = '0; slv_rvalid = '0; slv_rdata = '0;

    cycle(1'b1, 1'b0, 32'h0, 1'b0, N);
    cycle(1'b1, 1'b0, 32'h0, 1'b0, N);
    idle();
    chk("reset_rdata", data_rdata, 32'h0);
    chk("reset_err", 32'(data_err), 32'h0);

    // RAM read, 1-cycle slave
    use_next = 1'b1; next_data = 32'h12345678;
    cycle(1'b0, 1'b1, 32'h00100010, 1'b0, 0);
    chk("ram_gnt_c0", 32'(data_gnt), 32'h1);
    idle();
    chk("ram_rdata_c1", data_rdata, 32'h12345678);
    chk("ram_rvalid_c1", 32'(data_rvalid), 32'h1);
    use_next = 1'b0;

    // Unmapped read
    cycle(1'b0, 1'b1, 32'h30000000, 1'b0, N);
    chk("unmapped_gnt", 32'(data_gnt), 32'h1);
    chk("unmapped_noreq", 32'(slv_req), 32'h0);
    idle();
    chk("unmapped_rdata", data_rdata, 32'hDEADBEEF);
    chk("unmapped_err", 32'(data_err), 32'h1);

    // Back-to-back RAM reads with slow responses: third request stalls
    lat_min = 3; lat_max = 3;
    cycle(1'b0, 1'b1, 32'h00100000, 1'b0, 0);
    cycle(1'b0, 1'b1, 32'h00100004, 1'b0, 0);
    cycle(1'b0, 1'b1, 32'h00100008, 1'b0, 0);
    chk("full_stall_gnt", 32'(data_gnt), 32'h0);
    for (int k = 0; k < 6; k++) cycle(1'b0, 1'b1, 32'h00100008, 1'b0, 0);
    for (int k = 0; k < 6; k++) idle();

    // RAM outstanding, then GPIO waits for the FIFO to drain
    cycle(1'b0, 1'b1, 32'h00100020, 1'b0, 0);
    for (int k = 0; k < 5; k++) cycle(1'b0, 1'b1, 32'h20001000, 1'b1, 1);
    for (int k = 0; k < 5; k++) idle();

    // Reset with two outstanding, then stray responses
    cycle(1'b0, 1'b1, 32'h00100000, 1'b0, 0);
    cycle(1'b0, 1'b1, 32'h00100004, 1'b0, 0);
    cycle(1'b1, 1'b0, 32'h0, 1'b0, N);
    stray_pct = 100;
    idle();
    chk("post_reset_rvalid", 32'(data_rvalid), 32'h0);
    idle(); idle(); idle();
    chk("post_reset_rvalid_late", 32'(data_rvalid), 32'h0);
    stray_pct = 0; lat_min = 1; lat_max = 1;
    for (int k = 0; k < 4; k++) idle();

    // Profiling: 3 reads, 2 writes, 1 unmapped read from a clean reset
    cycle(1'b1, 1'b0, 32'h0, 1'b0, N);
    for (int k = 0; k < 3; k++) begin cycle(1'b0, 1'b1, rand_addr(k), 1'b0, k); idle(); end
    for (int k = 0; k < 2; k++) begin cycle(1'b0, 1'b1, rand_addr(0), 1'b1, 0); idle(); end
    cycle(1'b0, 1'b1, 32'h30000040, 1'b0, N);
    idle(); idle();
    chk("prof_rd_total", prof_rd, prof_exp(4));
    chk("prof_wr_total", prof_wr, prof_exp(2));
    chk("prof_err_total", prof_err, prof_exp(1));

    // Randomized traffic
    gnt_pct = 70; lat_min = 1; lat_max = 3; stray_pct = 20;
    for (int k = 0; k < 3000; k++) begin
      t = $urandom_range(N);
      cycle(($urandom_range(99) == 0), ($urandom_range(99) < 70), rand_addr(t), 1'($urandom), t);
    end
    stray_pct = 0; gnt_pct = 100;
    for (int k = 0; k < 6; k++) idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/data_bus_mux.md
# data_bus_mux

Parametrised data-side interconnect between the RI5CY core's data port and N_SLAVES memory-mapped targets, such as data RAM, GPIO and SPI. It decodes each request against per-slave base/mask windows, forwards the request/grant handshake, and tracks up to MAX_OUTSTANDING in-flight transactions in an order FIFO. Responses are routed back in order, and an internal error responder answers unmapped accesses. Optional performance counters are available.

## Interface
Parameters:
- N_SLAVES, 3, number of external slave ports (1..8)
- SLV_BASE, {32'h20002000, 32'h20001000, 32'h00100000}, packed N_SLAVES×32 base addresses; slave i in bits [32i+31:32i]
- SLV_MASK, {32'hFFFFF000, 32'hFFFFF000, 32'hFFFF8000}, packed N_SLAVES×32 decode masks
- MAX_OUTSTANDING, 2, order-FIFO depth (1..4)
- ERR_RDATA, 32'hDEADBEEF, read data returned for unmapped accesses

Ports:
- HCLK  in  1  clock; all state updates on rising edge
- HRESET  in  1  synchronous, active-high reset
- data_req  in  1  core request
- data_addr  in  32  byte address
- data_we  in  1  write enable
- data_be  in  4  byte enables
- data_wdata  in  32  write data
- data_gnt  out  1  request accepted this cycle
- data_rvalid  out  1  response valid
- data_rdata  out  32  response read data
- data_err  out  1  response is a decode error (qualified by data_rvalid)
- slv_req  out  N_SLAVES  one-hot request to slaves
- slv_addr, slv_we, slv_be, slv_wdata  out  32/1/4/32  broadcast copies of the core signals
- slv_gnt  in  N_SLAVES  per-slave grant
- slv_rvalid  in  N_SLAVES  per-slave response valid
- slv_rdata  in  32×N_SLAVES  packed per-slave read data
- prof_rd, prof_wr, prof_stall, prof_err  out  32 each  profiling counters

## Operation
- Decode: hit[i] = ((data_addr & SLV_MASK[i]) == SLV_BASE[i]). The lowest index wins on overlap. No hit selects the internal error target (index N_SLAVES).
- Stall condition: FIFO full, or FIFO non-empty and the decoded target differs from the most recently pushed target. While stalled: slv_req = 0, data_gnt = 0.
- Not stalled: slv_req[t] = data_req for an external target t, and data_gnt = slv_gnt[t]. For the error target, data_gnt = data_req.
- Push: data_req & data_gnt pushes the target index into the order FIFO.
- Response routing: the FIFO head index h selects the response.
  - h external: data_rvalid = slv_rvalid[h], data_rdata = slv_rdata[h], data_err = 0.
  - h = error: data_rvalid = 1, data_rdata = ERR_RDATA (writes also return this value), data_err = 1.
- Pop: data_rvalid pops the head. slv_rvalid from a non-head slave is ignored.
- Simultaneous push and pop are both performed, and the count is unchanged. A full FIFO still stalls even if a pop occurs in the same cycle.
- Count width: $clog2(MAX_OUTSTANDING+1); it never wraps past the depth. The FIFO read/write pointers wrap modulo MAX_OUTSTANDING.

## Timing
- Request path (data_gnt, slv_req) is combinational from data_req/data_addr and registered FIFO state; zero added latency.
- Response path is combinational from slv_rvalid/slv_rdata and the registered head.
- Minimum latency is one cycle from grant to data_rvalid; this holds for the error target and for 1-cycle slaves.
- Reset, while HRESET is high at a clock edge:
  - FIFO emptied and count = 0.
  - data_rvalid = 0, data_err = 0, data_rdata = 0 from the next cycle.
  - slv_req follows the decode. It is not masked by reset.
  - Profiling counters cleared.
- Reset mid-transaction: pending entries are discarded, and late slv_rvalid after reset is ignored because the FIFO is empty.

## Configuration
- DATA_BUS_PROFILE_EN defined: four 32-bit saturating counters (stick at 32'hFFFFFFFF).
  - prof_rd increments on each granted read.
  - prof_wr increments on each granted write.
  - prof_stall increments on each cycle with data_req = 1 and data_gnt = 0.
  - prof_err increments on each error response.
- Not defined: counters are not instantiated and all prof_* outputs are constant 0.

## Test plan
- Read RAM at 0x00100010, slave grants same cycle, rvalid next cycle with 0x12345678 -> data_gnt = 1 at cycle 0; data_rvalid = 1, data_rdata = 0x12345678, data_err = 0 at cycle 1.
- Unmapped read at 0x30000000 -> data_gnt = 1 immediately; next cycle data_rvalid = 1, data_rdata = 0xDEADBEEF, data_err = 1; no slv_req asserted.
- Back-to-back reads to RAM with MAX_OUTSTANDING = 2 and RAM rvalid delayed 3 cycles -> two grants, third request stalls (data_gnt = 0, prof_stall increments) until the first response pops.
- RAM read outstanding, then GPIO request at 0x20001000 -> GPIO stalled until the RAM response returns; GPIO is granted in the same cycle the FIFO empties.
- HRESET asserted with 2 outstanding entries, then a stray slv_rvalid[0] -> no data_rvalid; count = 0.
- DATA_BUS_PROFILE_EN defined; 3 reads, 2 writes, 1 unmapped read -> prof_rd = 4, prof_wr = 2, prof_err = 1.
